// File: rtl/softmax_prescale_pkg.sv
// softmax_pkg: shared Q4.12 constants and FSM state type for the
// softmax_approx datapath blocks (softmax_prescale, log2e_scale).
package softmax_pkg;

  localparam int unsigned Q412_W    = 16;
  localparam int unsigned Q412_FRAC = 12;

  // log2(e) in Q4.12 (5909 / 4096 ~= 1.4426)
  localparam logic [15:0] LOG2E_Q412 = 16'h1715;
  localparam logic [15:0] Q412_MIN   = 16'h8000;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/softmax_prescale_if.sv
// softmax_prescale_if: stream bus around softmax_prescale.
//   in_x/in_valid/in_last/in_ready : upstream logit stream
//   out_x/out_valid/out_last/out_ready : downstream y_i stream (to pow2_approx)
//   max_x : registered vector maximum
// master = upstream/downstream environment, slave = softmax_prescale.
interface softmax_prescale_if
  import softmax_pkg::*;
#(
  parameter int unsigned DW = Q412_W
);

  logic [DW-1:0] in_x;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] out_x;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] max_x;

  modport master (
    output in_x, in_valid, in_last, out_ready,
    input  in_ready, out_x, out_valid, out_last, max_x
  );

  modport slave (
    input  in_x, in_valid, in_last, out_ready,
    output in_ready, out_x, out_valid, out_last, max_x
  );

endinterface

// File: rtl/softmax_prescale_log2e_scale.sv
// log2e_scale: combinational y = round((x - max) * log2(e)) in Q4.12.
//   x_i   : signed Q4.12 element
//   max_i : signed Q4.12 vector maximum (max_i >= x_i)
//   y_o   : signed Q4.12 result, saturated to Q412_MIN on underflow
//   sat_o : high when y_o was saturated
module log2e_scale
  import softmax_pkg::*;
#(
  parameter int unsigned DW   = Q412_W,
  parameter int unsigned FRAC = Q412_FRAC
) (
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] max_i,
  output logic [DW-1:0] y_o,
  output logic          sat_o
);

  // Wide enough for a (DW+1)-bit difference times a DW-bit constant.
  localparam int unsigned PW = 2 * DW + 2;

  localparam logic signed [PW-1:0] K    = PW'(LOG2E_Q412);
  localparam logic signed [PW-1:0] HALF = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] diff_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rnd;

  always_comb begin
    diff     = $signed({x_i[DW-1], x_i}) - $signed({max_i[DW-1], max_i});
    diff_ext = {{(PW-DW-1){diff[DW]}}, diff};
    prod     = diff_ext * K;
    // Adding half an LSB before the arithmetic shift gives round-half-up.
    rnd      = (prod + HALF) >>> FRAC;
    // Result fits DW bits only if all bits above the DW sign bit match it;
    // the result is never positive-overflowing since x <= max.
    sat_o    = rnd[PW-1] & ~(&rnd[PW-1:DW-1]);
    y_o      = sat_o ? DW'(Q412_MIN) : rnd[DW-1:0];
  end

endmodule

// File: rtl/softmax_prescale.sv
// softmax_prescale: buffers one vector of Q4.12 logits while tracking its
// maximum, then streams y_i = (x_i - max) * log2(e) so that the downstream
// pow2_approx evaluates e^(x_i - max). All outputs are <= 0.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   en       : global enable; low freezes all state and gates handshakes
//   bus      : softmax_prescale_if.slave (input stream, output stream, max_x)
//   sat_flag : (only with SOFTMAX_PRESCALE_SAT_FLAG_EN) sticky flag, set when
//              any output of the current vector saturated, cleared on the
//              first input of the next vector
module softmax_prescale
  import softmax_pkg::*;
#(
  parameter int unsigned N_MAX = 64,
  parameter int unsigned DW    = Q412_W,
  parameter int unsigned FRAC  = Q412_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  softmax_prescale_if.slave    bus
`ifdef SOFTMAX_PRESCALE_SAT_FLAG_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int unsigned AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int unsigned CW = $clog2(N_MAX + 1);

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] out_x_q, out_x_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic [DW-1:0] mem_q [N_MAX];

  logic          in_ready_c;
  logic          in_hs;
  logic          out_hs;
  logic          last_hs;
  logic          vec_end;
  logic          ld;
  logic [DW-1:0] scl_y;
`ifdef SOFTMAX_PRESCALE_SAT_FLAG_EN
  logic          scl_sat;
  logic          sat_q, sat_d;
`else
  logic          scl_sat_unused;
`endif

  // ---------------- handshake decode ----------------
  assign in_hs   = bus.in_valid & in_ready_c;
  assign out_hs  = en & out_valid_q & bus.out_ready;
  assign last_hs = out_hs & out_last_q;
  assign vec_end = in_hs & (bus.in_last | (cnt_q == CW'(N_MAX - 1)));
  // Output register refills while elements remain and the slot is free or
  // being consumed this cycle; this gives one output per cycle.
  assign ld      = en & (state_q == DRAIN) & (rd_ptr_q != cnt_q)
                 & (~out_valid_q | bus.out_ready);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (vec_end) state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready_c = en & (state_q == LOAD);
  end

  // ---------------- buffer ----------------
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_q[cnt_q[AW-1:0]] <= bus.in_x;
    end
  end

  // ---------------- scaler ----------------
  log2e_scale #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_scale (
    .x_i   (mem_q[rd_ptr_q[AW-1:0]]),
    .max_i (max_q),
    .y_o   (scl_y),
`ifdef SOFTMAX_PRESCALE_SAT_FLAG_EN
    .sat_o (scl_sat)
`else
    .sat_o (scl_sat_unused)
`endif
  );

  // ---------------- datapath ----------------
  always_comb begin
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    max_d       = max_q;
    out_x_d     = out_x_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (in_hs) begin
      cnt_d = cnt_q + CW'(1);
      if ((cnt_q == '0) || ($signed(bus.in_x) > $signed(max_q))) begin
        max_d = bus.in_x;
      end
    end

    if (ld) begin
      out_x_d     = scl_y;
      out_valid_d = 1'b1;
      out_last_d  = (rd_ptr_q == (cnt_q - CW'(1)));
      rd_ptr_d    = rd_ptr_q + CW'(1);
    end else if (last_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_d       = '0;
      rd_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      max_q       <= '0;
      out_x_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (en) begin
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      max_q       <= max_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef SOFTMAX_PRESCALE_SAT_FLAG_EN
  always_comb begin
    sat_d = sat_q;
    if (in_hs && (cnt_q == '0)) begin
      sat_d = 1'b0;
    end
    if (ld && scl_sat) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_q <= 1'b0;
    end else if (en) begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`endif

  // ---------------- outputs ----------------
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = en & out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_last  = out_last_q;
  assign bus.max_x     = max_q;

endmodule
